mcp_sequencer: RTL

MCP_SEQUENCER -- requirements
Module: mcp_sequencer

---
 rtl/mcp_pkg.sv | 28 ++
 rtl/mcp_watchdog.sv | 35 +++
 rtl/mcp_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mcp_pkg.sv
// Shared types and constants for the multi-cycle processor sequencer.
package mcp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_ALU,
    ST_EXEC_MEM,
    ST_HALT
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_OUT   = 3'b101;
  localparam logic [2:0] OP_SHL   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam int RET_W = 16;

  function automatic logic is_alu(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/mcp_watchdog.sv
// Counts consecutive un-acked request cycles; flags expiry on the last one.
module mcp_watchdog
  import mcp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_ack,
  output logic o_expire
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIM =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] r_cnt;

  // An ack in the limit cycle wins over expiry.
  assign o_expire = (TIMEOUT_CYCLES != 0) && i_en &&
                    !i_ack && (r_cnt == LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_en || i_ack || o_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mcp_sequencer.sv
// Multi-cycle fetch/decode/execute controller with transfer watchdog.
module mcp_sequencer
  import mcp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [2:0]       opCode,
  input  logic             MemAck,
  output logic             IrLoad,
  output logic             PcInc,
  output logic             MemReq,
  output logic             Rd,
  output logic             Wr,
  output logic             IOMemSel,
  output logic             AddSub,
  output logic             LoadAcc,
  output logic             AcSel,
  output logic             Shift,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [RET_W-1:0] retired
);

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_op;
  logic [RET_W-1:0] r_ret;
  logic             r_err;
  logic             w_retire;
  logic             w_set_err;
  logic             w_expire;
  logic             w_rd_op;

  mcp_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .i_en    (MemReq),
    .i_ack   (MemAck),
    .o_expire(w_expire)
  );

  assign w_rd_op = (r_op == OP_LOAD) || (r_op == OP_IN);
  assign err     = r_err;
  assign retired = r_ret;

  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    w_set_err = 1'b0;
    IrLoad    = 1'b0;
    PcInc     = 1'b0;
    MemReq    = 1'b0;
    Rd        = 1'b0;
    Wr        = 1'b0;
    IOMemSel  = 1'b0;
    AddSub    = 1'b0;
    LoadAcc   = 1'b0;
    AcSel     = 1'b0;
    Shift     = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (run) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        busy   = 1'b1;
        MemReq = 1'b1;
        Rd     = 1'b1;
        if (MemAck) begin
          IrLoad = 1'b1;
          PcInc  = 1'b1;
          w_next = ST_DECODE;
        end else if (w_expire) begin
          w_set_err = 1'b1;
          w_next    = ST_HALT;
        end
      end
      // Branch on the live opcode; it is latched on this same edge.
      ST_DECODE: begin
        busy = 1'b1;
        if (opCode == OP_HALT) begin
          w_retire = 1'b1;
          w_next   = ST_HALT;
        end else if (is_alu(opCode)) begin
          w_next = ST_EXEC_ALU;
        end else begin
          w_next = ST_EXEC_MEM;
        end
      end
      ST_EXEC_ALU: begin
        busy     = 1'b1;
        LoadAcc  = 1'b1;
        AcSel    = 1'b1;
        AddSub   = (r_op == OP_SUB);
        Shift    = (r_op == OP_SHL);
        w_retire = 1'b1;
        w_next   = run ? ST_FETCH : ST_IDLE;
      end
      ST_EXEC_MEM: begin
        busy     = 1'b1;
        MemReq   = 1'b1;
        Rd       = w_rd_op;
        Wr       = !w_rd_op;
        IOMemSel = (r_op == OP_IN) || (r_op == OP_OUT);
        if (MemAck) begin
          LoadAcc  = w_rd_op;
          w_retire = 1'b1;
          w_next   = run ? ST_FETCH : ST_IDLE;
        end else if (w_expire) begin
          w_set_err = 1'b1;
          w_next    = ST_HALT;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_LOAD;
      r_ret   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) r_op <= opCode;
      if (w_retire) r_ret <= r_ret + 1'b1;
      if (w_set_err) r_err <= 1'b1;
    end
  end

endmodule
